// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: synchronises rx, validates the start bit, samples each bit
// at mid-period and hands completed bytes to the consumer via a valid/ack handshake.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    input  logic       rxack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic [7:0]       rxbyte_r;
    logic             rxvalid_r;
    logic             frame_err_r;
    logic             overrun_r;
    logic             busy_r;

    assign rxbyte    = rxbyte_r;
    assign rxvalid   = rxvalid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM with handshake and one-cycle error pulses.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            rxbyte_r    <= 8'h00;
            rxvalid_r   <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            if (rxack && rxvalid_r) begin
                rxvalid_r <= 1'b0;
            end else begin
                rxvalid_r <= rxvalid_r;
            end
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (!rx_sync_r) begin
                        state_r <= ST_START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        if (!rx_sync_r) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Start bit gone by mid-period: treat as a glitch.
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r <= '0;
                        if (rx_sync_r) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            // An ack this cycle frees the holding register for the new byte.
                            if (!rxvalid_r || rxack) begin
                                rxbyte_r  <= shift_r;
                                rxvalid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    cnt_r <= '0;
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
